// File: rtl/axi_lite_pkg.sv
// Shared definitions for the core-side AXI-lite master: FSM state encoding and
// AXI response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/core_axi_lite_master.sv
// Bridges one core load/store request at a time onto AXI-lite and returns a
// one-cycle completion pulse carrying load data and an error flag.
module core_axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  // Core request / response. Handshakes everywhere follow AXI rules: a transfer
  // happens on a rising edge where valid && ready; a raised valid and its
  // payload hold until that edge, and no valid depends combinationally on ready.
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  // Write address channel
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  // Write data channel
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  // Write response channel
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // Read address channel
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  // Read data channel
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  state_t                    state;
  logic                      aw_done;
  logic                      w_done;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [DATA_WIDTH/8-1:0]   strb_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic aw_complete;
  logic w_complete;

  // req_ready is forced low while rst is held so every ready output reads 0 in reset.
  assign req_ready   = (state == IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign aw_complete = aw_done || aw_hs;
  assign w_complete  = w_done || w_hs;

  assign bready     = (state == WRESP);
  assign rready     = (state == RDATA);
  assign resp_valid = (state == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = data_q;
  assign wstrb  = strb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            data_q  <= req_wdata;
            strb_q  <= req_wmask;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (req_wen) begin
              state   <= WRITE;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= READ;
              arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          // AW and W retire independently; the later of the two moves us on.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_complete && w_complete) begin
            state <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            err_q <= (bresp != RESP_OKAY);
            state <= DONE;
          end
        end
        READ: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            rdata_q <= rdata;
            err_q   <= (rresp != RESP_OKAY);
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_axi_lite_master.sv
// Directed plus randomized checks of the AXI-lite master against a byte-level
// memory model, driven through a delay-configurable AXI-lite slave responder.
module tb_core_axi_lite_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

  core_axi_lite_master #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave knobs and per-transaction handshake markers
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  bit err_inj = 0;
  bit aw_hs = 0, w_hs = 0, ar_hs = 0;

  logic [63:0] slave_mem [logic [63:0]];
  logic [63:0] s_awaddr, s_wdata, s_araddr;
  logic [7:0]  s_wstrb;
  bit aw_got, w_got, ar_got;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;

  // Slave responder: decisions at negedge, so they are seen by the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 2'b00; rresp = 2'b00; rdata = '0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (bvalid) begin
        bvalid = 0; bresp = 2'b00; aw_got = 0; w_got = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
      end else begin
        if (awready) begin
          awready = 0; aw_got = 1; aw_hs = 1;
        end else if (awvalid && !aw_got) begin
          if (aw_wait >= aw_delay) begin awready = 1; s_awaddr = awaddr; end
          else aw_wait++;
        end
        if (wready) begin
          wready = 0; w_got = 1; w_hs = 1;
        end else if (wvalid && !w_got) begin
          if (w_wait >= w_delay) begin wready = 1; s_wdata = wdata; s_wstrb = wstrb; end
          else w_wait++;
        end
        if (aw_got && w_got) begin
          if (b_wait >= b_delay) begin
            bvalid = 1;
            bresp = err_inj ? 2'b10 : 2'b00;
            if (!err_inj) begin
              logic [63:0] bm, old;
              bm = '0;
              for (int b = 0; b < 8; b++) if (s_wstrb[b]) bm[8*b +: 8] = 8'hFF;
              old = slave_mem.exists(s_awaddr) ? slave_mem[s_awaddr] : 64'h0;
              slave_mem[s_awaddr] = (old & ~bm) | (s_wdata & bm);
            end
          end else b_wait++;
        end
      end
      if (rvalid) begin
        rvalid = 0; rresp = 2'b00; ar_got = 0; ar_wait = 0; r_wait = 0;
      end else begin
        if (arready) begin
          arready = 0; ar_got = 1; ar_hs = 1;
        end else if (arvalid && !ar_got) begin
          if (ar_wait >= ar_delay) begin arready = 1; s_araddr = araddr; end
          else ar_wait++;
        end
        if (ar_got) begin
          if (r_wait >= r_delay) begin
            rvalid = 1;
            rresp = err_inj ? 2'b10 : 2'b00;
            rdata = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : 64'h0;
          end else r_wait++;
        end
      end
    end
  end

  // Reference model: byte-addressed lanes of 64-bit words
  logic [63:0] model_mem [logic [63:0]];
  logic [63:0] last_rd = '0;

  function automatic logic [63:0] model_read(input logic [63:0] a);
    return model_mem.exists(a) ? model_mem[a] : 64'h0;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] cur;
    cur = model_read(a);
    for (int b = 0; b < 8; b++) if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
    model_mem[a] = cur;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one request, monitored every cycle until its completion pulse
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] wm, input bit err, input string tag);
    logic [63:0] exp_rd;
    int lat, viol, guard;
    bit all_zero;
    all_zero = (aw_delay == 0 && w_delay == 0 && ar_delay == 0 && b_delay == 0 && r_delay == 0);
    err_inj = err;
    aw_hs = 0; w_hs = 0; ar_hs = 0;
    if (wen) begin
      if (!err) model_write(addr, wd, wm);
      exp_rd = last_rd;
    end else begin
      exp_rd = model_read(addr);
    end
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    chk($sformatf("%s_ready", tag), {63'h0, req_ready}, 64'h1);
    lat = 0; viol = 0;
    do begin
      @(negedge clk); #1;
      if (lat == 0) req_valid = 0;
      lat++;
      if (!resp_valid) begin
        if (req_ready) viol++;
        if (wen) begin
          if (!aw_hs) begin if (!awvalid || awaddr !== addr) viol++; end
          else if (awvalid) viol++;
          if (!w_hs) begin if (!wvalid || wdata !== wd || wstrb !== wm) viol++; end
          else if (wvalid) viol++;
          if (!(aw_hs && w_hs) && bready) viol++;
          if (arvalid || rready) viol++;
        end else begin
          if (!ar_hs) begin if (!arvalid || araddr !== addr) viol++; end
          else if (arvalid) viol++;
          if (!ar_hs && rready) viol++;
          if (awvalid || wvalid || bready) viol++;
        end
      end
    end while (!resp_valid && lat < 200);
    chk($sformatf("%s_resp", tag), {63'h0, resp_valid}, 64'h1);
    if (all_zero) chk($sformatf("%s_lat", tag), lat, 3);
    chk($sformatf("%s_err", tag), {63'h0, resp_err}, {63'h0, err});
    chk($sformatf("%s_rdata", tag), resp_rdata, exp_rd);
    chk($sformatf("%s_proto", tag), viol, 0);
    if (!wen) last_rd = exp_rd;
    @(negedge clk); #1;
    chk($sformatf("%s_pulse", tag), {62'h0, resp_valid, req_ready}, 64'h1);
  endtask

  initial begin
    int guard;
    rst = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valids", {58'h0, awvalid, wvalid, arvalid, bready, rready, resp_valid}, 64'h0);
    chk("rst_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_resp", {resp_rdata[62:0], resp_err}, 64'h0);
    chk("rst_payload", awaddr | wdata | {56'h0, wstrb}, 64'h0);
    @(negedge clk); rst = 0;
    #1;
    chk("idle_ready", {63'h0, req_ready}, 64'h1);

    // Zero-wait store then load of the same word
    do_req(1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, "store0");
    do_req(0, 64'h10, '0, '0, 0, "load0");
    chk("load0_const", resp_rdata, 64'hDEADBEEF_CAFEF00D);

    // W handshakes well before AW
    aw_delay = 4; w_delay = 0;
    do_req(1, 64'h18, 64'h0123_4567_89AB_CDEF, 8'hA5, 0, "skew_w");
    aw_delay = 0; w_delay = 4; b_delay = 2;
    do_req(1, 64'h28, 64'hFEDC_BA98_7654_3210, 8'h3C, 0, "skew_aw");
    aw_delay = 0; w_delay = 0; b_delay = 0;

    // Error responses on read and write, then a normal request
    do_req(0, 64'h10, '0, '0, 1, "rd_err");
    do_req(1, 64'h30, 64'h5555_5555_5555_5555, 8'hFF, 1, "wr_err");
    do_req(0, 64'h30, '0, '0, 0, "after_err");

    // Partial store leaves untouched bytes intact
    do_req(1, 64'h20, 64'hAAAAAAAA_AAAAAAAA, 8'hFF, 0, "fill20");
    do_req(1, 64'h20, 64'h11223344_55667788, 8'h0F, 0, "part20");
    do_req(0, 64'h20, '0, '0, 0, "load20");
    chk("partial_const", resp_rdata, 64'hAAAAAAAA_55667788);

    // Reset while waiting for read data
    r_delay = 30; err_inj = 0;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 64'h20;
    @(negedge clk); req_valid = 0;
    guard = 0;
    while (!rready && guard < 50) begin @(negedge clk); guard++; end
    chk("rdata_reached", {63'h0, rready}, 64'h1);
    #2 rst = 1;
    #1;
    chk("midrst_outs", {60'h0, arvalid, rready, resp_valid, req_ready}, 64'h0);
    @(negedge clk); @(negedge clk);
    #1 rst = 0;
    #1;
    chk("midrst_ready", {63'h0, req_ready}, 64'h1);
    chk("midrst_rdata", resp_rdata, 64'h0);
    last_rd = '0;
    r_delay = 0;
    do_req(0, 64'h20, '0, '0, 0, "post_rst");

    // Randomized traffic with random slave delays
    for (int i = 0; i < 24; i++) begin
      logic w;
      logic [63:0] a, d;
      logic [7:0] m;
      bit e;
      w = 1'($urandom_range(0, 1));
      a = 64'($urandom_range(0, 7)) * 8;
      d = {$urandom, $urandom};
      m = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 7) == 0);
      if (i % 3 == 0) begin
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
      end else begin
        aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
        ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
        r_delay  = $urandom_range(0, 3);
      end
      do_req(w, a, d, m, e, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_axi_lite_master.md
Name: core_axi_lite_master

Overview:
- Upstream feeder of the AXI-lite RAM slave. Converts one core-side memory request (load or store) into an AXI-lite read or write transaction, then returns the completion to the pipeline.
- One transaction is outstanding at a time. AW and W are issued concurrently and complete independently.

Parameters:
- DATA_WIDTH, 64, AXI/core data width.
- ADDR_WIDTH, 64, AXI/core address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge idle, accepts request
- req_wen  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address, passed unmodified
- req_wdata  in  DATA_WIDTH  store data
- req_wmask  in  DATA_WIDTH/8  store byte strobes
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  load data, valid with resp_valid
- resp_err  out  1  xRESP!=OKAY, valid with resp_valid
- awaddr/awvalid  out  ADDR_WIDTH/1  write address channel
- awready  in  1  write address channel
- wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- wready  in  1  write data channel
- bresp/bvalid  in  2/1  write response channel
- bready  out  1  write response channel
- araddr/arvalid  out  ADDR_WIDTH/1  read address channel
- arready  in  1  read address channel
- rdata/rresp/rvalid  in  DATA_WIDTH/2/1  read data channel
- rready  out  1  read data channel

Behaviour:
- Reset values (async, rst=1): state=IDLE; all valid and ready outputs 0; resp_* 0; registered addr/data/strb 0.
- req_ready = (state==IDLE). A request is accepted on req_valid&&req_ready. addr, wdata, wmask and wen are latched that edge.
- IDLE -> WRITE if wen, else READ.
- WRITE:
  - awvalid=1 and wvalid=1 from the cycle after accept.
  - Each valid drops the cycle after its own handshake. aw_done and w_done flags are tracked separately.
  - When both flags are set -> WRESP.
  - Simultaneous AW and W handshake in one cycle is legal and sets both flags.
- WRESP: bready=1. On bvalid -> DONE with err=(bresp!=2'b00).
- READ: arvalid=1 until arready -> RDATA.
- RDATA: rready=1. On rvalid, capture rdata and err=(rresp!=2'b00) -> DONE.
- DONE: resp_valid=1 for exactly one cycle with captured data/err -> IDLE.
- Latency: earliest new accept is the cycle after DONE.
  - Zero-wait slave: write accept to resp_valid = 3 cycles; read = 3 cycles.
- resp_rdata holds its value until the next read completes. It is 0 after reset and meaningless for stores.
- Valid-signal stability: once asserted, awvalid/wvalid/arvalid and their payloads hold until handshake. Valids never depend combinationally on ready.
- bready and rready are asserted only in WRESP and RDATA. Stray bvalid or rvalid in other states is ignored.
- Reset mid-transaction: immediate return to IDLE, all outputs deasserted, no resp_valid. The slave is reset by the same rst.
- No timeout: a slave that never responds stalls the bridge indefinitely.

Decomposition:
- Shared package axi_lite_pkg: state enum (IDLE, WRITE, WRESP, READ, RDATA, DONE), RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Single flat module. No sub-module.

Test Plan:
- Store, zero-wait: addr=0x10, wdata=0xDEADBEEF_CAFEF00D, wmask=0xFF -> awaddr=0x10 and wstrb=0xFF in the same cycle; resp_valid 3 cycles after accept; resp_err=0.
- Load after store: addr=0x10 -> araddr=0x10; resp_rdata=0xDEADBEEF_CAFEF00D; resp_err=0.
- Skewed handshakes: wready 4 cycles before awready -> wvalid drops after its handshake; awvalid holds; bready rises only after both handshakes; req_ready=0 throughout.
- Error response: slave returns rresp=2'b10 -> resp_valid=1 with resp_err=1; next request accepted normally.
- Partial store: wmask=0x0F, wdata=0x11223344_55667788 to addr=0x20; then load 0x20 -> upper 4 bytes unchanged from prior contents.
- Reset in RDATA: rst pulsed while waiting for rvalid -> arvalid, rready and resp_valid all 0 same cycle; req_ready=1 after rst release.
